rr_arbiter_1hot_8: RTL

RR_ARBITER_1HOT_8 -- requirements
Module: rr_arbiter_1hot_8

---
 rtl/rr_arbiter_1hot_8.sv | 89 ++++++++
 1 files changed

// File: rtl/rr_arbiter_1hot_8.sv
// Eight-way round-robin arbiter with a one-hot grant and a bounded hold time.
// When other requesters are waiting, the current owner is preempted after MAX_HOLD cycles.
module rr_arbiter_1hot_8 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [HW-1:0] hold_cnt;

    logic [7:0]    cand;
    logic          win_found;
    logic [2:0]    win_idx;

    // The owner's own bit is masked out. A releasing owner has already dropped
    // its bit, so one mask serves the IDLE, release and preempt cases.
    always_comb begin
        // NOTE: every output gets a default first so that no latch is inferred.
        cand      = req & ~gnt;
        win_found = 1'b0;
        win_idx   = ptr;
        // The scan runs from farthest to nearest, so the nearest hit is written last.
        for (int k = 7; k >= 0; k--) begin
            if (cand[ptr + 3'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 3'(k);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the reset is asynchronous, so the outputs clear without waiting for a clock edge.
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        state     <= GRANT;
                        gnt       <= 8'b1 << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HOLD_ONE;
                        ptr       <= win_idx + 3'd1;
                    end
                end
                GRANT: begin
                    if (!req[gnt_idx] || (hold_cnt == HOLD_MAX && en && win_found)) begin
                        if (en && win_found) begin
                            gnt       <= 8'b1 << win_idx;
                            gnt_idx   <= win_idx;
                            hold_cnt  <= HOLD_ONE;
                            ptr       <= win_idx + 3'd1;
                        end else begin
                            state     <= IDLE;
                            gnt       <= 8'h00;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
